// File: rtl/mem_access_pkg.sv
// Shared types, FSM states and RV32I load/store encodings for mem_access.
// Lane-packing helpers used by the store path and the misalignment trap.
package mem_access_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte enables for a store; unknown widths write nothing.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   return 4'b0001 << a;
      F3_SH:   return 4'b0011 << a;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic word_t store_wdata(input logic [2:0] f3, input word_t data);
    case (f3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Low funct3 bits give the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Combinational lane select and sign/zero extension of a load response word.
module load_extend
  import mem_access_pkg::*;
(
  input  word_t       rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output word_t       value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/halfword lane and extend it to a full word.
  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_s[7]}}, byte_s};
      F3_LH:   value = {{16{half_s[15]}}, half_s};
      F3_LBU:  value = {24'd0, byte_s};
      F3_LHU:  value = {16'd0, half_s};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Stage-4 memory access unit: ALU pass-through, loads and stores over a valid/ready port.
// Optional macro MISALIGN_TRAP_EN adds the misalign output and traps unaligned accesses.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  word_t       eval,
  input  word_t       store_data,
  input  logic [4:0]  rd,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output word_t       dmem_addr,
  output word_t       dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  word_t       dmem_rdata,
  output logic        out_valid,
  output word_t       out_value,
  output logic [4:0]  out_rd
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  state_t      state_r;
  logic        req_valid_r;
  logic        we_r;
  word_t       addr_r;
  word_t       wdata_r;
  logic [3:0]  wstrb_r;
  logic [2:0]  funct3_r;
  logic [1:0]  a_lo_r;
  logic [4:0]  rd_r;
  logic        out_valid_r;
  word_t       out_value_r;
  logic [4:0]  out_rd_r;
  word_t       ext_s;
  logic        mem_op_s;
  logic        trap_s;

  assign mem_op_s = in_valid & (is_load | is_store);

`ifdef MISALIGN_TRAP_EN
  logic misalign_r;
  assign trap_s   = mem_op_s & is_misaligned(funct3, eval[1:0]);
  assign misalign = misalign_r;
`else
  assign trap_s   = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (a_lo_r),
    .funct3  (funct3_r),
    .value   (ext_s)
  );

  assign stall_out      = (state_r != ST_IDLE);
  assign dmem_req_valid = req_valid_r;
  assign dmem_we        = we_r;
  assign dmem_addr      = addr_r;
  assign dmem_wdata     = wdata_r;
  assign dmem_wstrb     = wstrb_r;
  assign out_valid      = out_valid_r;
  assign out_value      = out_value_r;
  assign out_rd         = out_rd_r;

  // Access FSM; request fields are held in registers so they stay stable until ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      req_valid_r <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
      funct3_r    <= 3'd0;
      a_lo_r      <= 2'd0;
      rd_r        <= 5'd0;
      out_valid_r <= 1'b0;
      out_value_r <= 32'd0;
      out_rd_r    <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_r  <= 1'b0;
`endif
    end else begin
      out_valid_r <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_r  <= (state_r == ST_IDLE) & trap_s;
`endif
      case (state_r)
        ST_IDLE: begin
          if (trap_s) begin
            out_valid_r <= 1'b1;
            out_value_r <= 32'd0;
            out_rd_r    <= 5'd0;
          end else if (mem_op_s) begin
            state_r     <= ST_REQ;
            req_valid_r <= 1'b1;
            we_r        <= is_store;
            addr_r      <= {eval[31:2], 2'b00};
            wdata_r     <= is_store ? store_wdata(funct3, store_data) : 32'd0;
            wstrb_r     <= is_store ? store_strb(funct3, eval[1:0]) : 4'd0;
            funct3_r    <= funct3;
            a_lo_r      <= eval[1:0];
            rd_r        <= rd;
          end else if (in_valid) begin
            out_valid_r <= 1'b1;
            out_value_r <= eval;
            out_rd_r    <= rd;
          end
        end
        ST_REQ: begin
          // Any response seen here belongs to nothing and is dropped.
          if (dmem_req_ready) begin
            req_valid_r <= 1'b0;
            we_r        <= 1'b0;
            wstrb_r     <= 4'd0;
            if (we_r) begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b1;
              out_value_r <= 32'd0;
              out_rd_r    <= 5'd0;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rsp_valid) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b1;
            out_value_r <= ext_s;
            out_rd_r    <= rd_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_valid_r <= 1'b0;
          we_r        <= 1'b0;
          wstrb_r     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  in  1  stage-3 result valid this cycle.
REQ-004 SHALL have ports is_load, is_store  in  1 each  op class; both low = ALU op pass-through.
REQ-005 SHALL have port funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-006 SHALL have port eval  in  word  stage-3 ALU result; effective address for loads and stores.
REQ-007 SHALL have ports store_data  in  word  and rd  in  5  destination register.
REQ-008 SHALL have port stall_out  out  1  upstream hold request.
REQ-009 SHALL have ports dmem_req_valid out 1, dmem_req_ready in 1, dmem_we out 1, dmem_addr out word, dmem_wdata out word, dmem_wstrb out 4.
REQ-010 SHALL have ports dmem_rsp_valid  in  1  and dmem_rdata  in  word.
REQ-011 SHALL have ports out_valid out 1, out_value out word, out_rd out 5  to stage 5.

Function
REQ-012 SHALL implement FSM IDLE, REQ, WAIT; stall_out = (state != IDLE), combinational.
REQ-013 SHALL accept inputs only in IDLE with in_valid=1; inputs SHALL be ignored otherwise.
REQ-014 ALU op SHALL produce out_valid=1, out_value=eval, out_rd=rd on the next cycle; state stays IDLE.
REQ-015 Load/store accept SHALL capture address, data, funct3 and rd, then enter REQ.
REQ-016 In REQ: dmem_req_valid=1, dmem_addr={eval[31:2],2'b00}; request fields SHALL be stable until dmem_req_ready=1.
REQ-017 Store: dmem_we=1; wdata replicates byte/half across lanes; wstrb = SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111.
REQ-018 Store handshake (valid and ready) SHALL go to IDLE with out_valid=1, out_rd=0 next cycle.
REQ-019 Load handshake SHALL go to WAIT; dmem_rsp_valid in REQ SHALL be ignored.
REQ-020 In WAIT, dmem_rsp_valid=1 SHALL register the lane-selected, sign/zero-extended value with out_valid=1 next cycle, then go to IDLE.
REQ-021 Best case: ALU latency 1; store latency 2; load latency 3 with ready in cycle 1 and response in cycle 2.
REQ-022 out_valid SHALL be a single-cycle pulse per accepted op.
REQ-023 A new op SHALL be acceptable in the same cycle out_valid is high.

Reset
REQ-024 Reset SHALL force state=IDLE and out_valid=0, out_value=0, out_rd=0, dmem_req_valid=0, dmem_we=0, wstrb=0.
REQ-025 Reset mid-REQ/WAIT SHALL abandon the op; a late dmem_rsp_valid in IDLE SHALL be ignored.

Configuration
REQ-026 Macro MISALIGN_TRAP_EN defined: port misalign out 1 is added.
REQ-027 With the macro, a halfword access at a[0]=1 or a word access at a[1:0]!=0 SHALL issue no request; next cycle misalign=1, out_valid=1, out_rd=0.
REQ-028 Without the macro there SHALL be no misalign port; address low bits beyond lane selection are ignored.

Structure
REQ-029 Shared package SHALL hold the word typedef, the FSM state enum and the funct3 load/store encodings.
REQ-030 SHALL instantiate sub-module load_extend, combinational: rdata, a[1:0], funct3 -> extended word.

Verification
REQ-031 ALU op, eval=0x0000_1234, rd=5 -> next cycle out_valid=1, out_value=0x1234, out_rd=5.
REQ-032 SB eval=0x103, store_data=0xAB, ready=1 -> addr 0x100, wstrb 1000, wdata 0xABABABAB; out_valid 2 cycles after accept.
REQ-033 LB eval=0x202, rdata=0x0080_0000 -> out_value 0xFFFFFF80; LBU -> 0x00000080.
REQ-034 LW with ready low for 3 cycles -> req fields stable, stall_out=1 throughout, out_valid 1 cycle after rsp.
REQ-035 Reset asserted in WAIT, then rsp_valid=1 -> no out_valid; state IDLE.
REQ-036 With MISALIGN_TRAP_EN, LW eval=0x102 -> no dmem_req_valid; misalign=1 next cycle.
